// File: rtl/cb_seq_pkg.sv
// Shared types for the CB bit-op sequencer and the ALU it drives.
// Control-word enums, function constants and sequencer states.
package cb_seq_pkg;

  typedef enum logic [1:0] {
    NO_OE  = 2'd0,
    BS_OE  = 2'd1,
    SH_OE  = 2'd2,
    RES_OE = 2'd3
  } oe_t;

  typedef enum logic {
    NO_LD  = 1'b0,
    BUS_LD = 1'b1
  } ld_t;

  typedef enum logic [1:0] {
    NO_SH   = 2'd0,
    SH_LEFT = 2'd1,
    SH_RGHT = 2'd2,
    SH_SWAP = 2'd3
  } sh_t;

  typedef struct packed {
    logic [2:0] bs;
    oe_t        oe;
    ld_t        la;
    ld_t        lb;
    sh_t        sh;
    logic       r;
    logic       s;
    logic       v;
    logic       ne;
    logic       ci;
    logic       l;
    logic       h;
  } alu_ctl_t;

  typedef struct packed {
    logic r;
    logic s;
    logic v;
    logic ne;
    logic ci;
  } fn_t;

  localparam fn_t FN_AND  = '{r: 1'b0, s: 1'b1, v: 1'b0, ne: 1'b0, ci: 1'b1};
  localparam fn_t FN_ANDN = '{r: 1'b0, s: 1'b1, v: 1'b0, ne: 1'b1, ci: 1'b1};
  localparam fn_t FN_OR   = '{r: 1'b1, s: 1'b1, v: 1'b0, ne: 1'b0, ci: 1'b0};

  localparam alu_ctl_t IDLE_CTL = '{
    bs: 3'd0, oe: NO_OE, la: NO_LD, lb: NO_LD, sh: NO_SH,
    r: 1'b0, s: 1'b0, v: 1'b0, ne: 1'b0, ci: 1'b0,
    l: 1'b0, h: 1'b0
  };

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    BSEL = 3'd2,
    OPND = 3'd3,
    RES  = 3'd4,
    WB   = 3'd5,
    WR   = 3'd6
  } state_t;

  function automatic fn_t fn_of(input logic [1:0] kind);
    fn_t f;
    unique case (kind)
      2'b01:   f = FN_AND;
      2'b10:   f = FN_ANDN;
      default: f = FN_OR;
    endcase
    return f;
  endfunction

  function automatic alu_ctl_t ctl_bsel(input logic [2:0] b);
    alu_ctl_t c;
    c    = IDLE_CTL;
    c.bs = b;
    c.oe = BS_OE;
    c.lb = BUS_LD;
    return c;
  endfunction

  // res=0 gives the operand-load word, res=1 the result-output word
  function automatic alu_ctl_t ctl_fn(input fn_t f, input logic res);
    alu_ctl_t c;
    c = IDLE_CTL;
    {c.r, c.s, c.v, c.ne, c.ci} = f;
    if (res) begin
      c.oe = RES_OE;
      c.h  = 1'b1;
    end else begin
      c.oe = SH_OE;
      c.la = BUS_LD;
      c.sh = NO_SH;
      c.l  = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/cb_bit_seq.sv
// Micro-sequencer for CB-prefixed BIT/RES/SET b,r and b,(HL).
// Drives the ALU control word and performs flag or byte write-back.
module cb_bit_seq
  import cb_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] opcode,
  output logic       illegal,
  output logic       busy,
  output logic       done,
  input  logic [7:0] reg_data,
  output logic       mem_rd_req,
  input  logic       mem_rd_ack,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_req,
  input  logic       mem_wr_ack,
  output logic [7:0] mem_wr_data,
  output alu_ctl_t   alu_ctl,
  output logic [7:0] alu_op,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  output logic       wb_en,
  output logic [2:0] wb_sel,
  output logic [7:0] wb_data,
  output logic       flag_we,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_h
);

  state_t     state;
  logic [7:0] op;
  logic [7:0] mem_byte;
  logic       done_q;
  fn_t        fn;
  logic       is_bit;
  logic       is_hl;

  assign fn     = fn_of(op[7:6]);
  assign is_bit = (op[7:6] == 2'b01);
  assign is_hl  = (op[2:0] == 3'd6);

  // write completion is only known in the ack cycle itself
  assign done   = done_q | (mem_wr_req & mem_wr_ack);
  assign flag_z = flag_we & alu_zero;
  assign flag_n = 1'b0;
  assign flag_h = flag_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op          <= 8'h00;
      mem_byte    <= 8'h00;
      done_q      <= 1'b0;
      illegal     <= 1'b0;
      busy        <= 1'b0;
      mem_rd_req  <= 1'b0;
      mem_wr_req  <= 1'b0;
      mem_wr_data <= 8'h00;
      alu_ctl     <= IDLE_CTL;
      alu_op      <= 8'h00;
      wb_en       <= 1'b0;
      wb_sel      <= 3'd0;
      wb_data     <= 8'h00;
      flag_we     <= 1'b0;
    end else begin
      illegal <= 1'b0;
      done_q  <= 1'b0;
      wb_en   <= 1'b0;
      flag_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (opcode[7:6] == 2'b00) begin
              illegal <= 1'b1;
            end else begin
              op   <= opcode;
              busy <= 1'b1;
              if (opcode[2:0] == 3'd6) begin
                state      <= RD;
                mem_rd_req <= 1'b1;
              end else begin
                state   <= BSEL;
                alu_ctl <= ctl_bsel(opcode[5:3]);
              end
            end
          end
        end
        RD: begin
          if (mem_rd_ack) begin
            mem_byte   <= mem_rd_data;
            mem_rd_req <= 1'b0;
            state      <= BSEL;
            alu_ctl    <= ctl_bsel(op[5:3]);
          end
        end
        BSEL: begin
          state   <= OPND;
          alu_ctl <= ctl_fn(fn, 1'b0);
          alu_op  <= is_hl ? mem_byte : reg_data;
        end
        OPND: begin
          state   <= RES;
          alu_ctl <= ctl_fn(fn, 1'b1);
          if (is_bit) begin
            flag_we <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        RES: begin
          alu_ctl <= IDLE_CTL;
          alu_op  <= 8'h00;
          if (is_bit) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (is_hl) begin
            state       <= WR;
            mem_wr_req  <= 1'b1;
            mem_wr_data <= alu_result;
          end else begin
            state   <= WB;
            wb_en   <= 1'b1;
            wb_sel  <= op[2:0];
            wb_data <= alu_result;
            done_q  <= 1'b1;
          end
        end
        WB: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        WR: begin
          if (mem_wr_ack) begin
            mem_wr_req <= 1'b0;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cb_bit_seq.sv
// Bench for cb_bit_seq: behavioural ALU, memory responder and
// bit-op reference computed directly from BIT/RES/SET semantics.
module tb_cb_bit_seq;
  import cb_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] opcode;
  logic       illegal;
  logic       busy;
  logic       done;
  logic [7:0] reg_data;
  logic       mem_rd_req;
  logic       mem_rd_ack;
  logic [7:0] mem_rd_data;
  logic       mem_wr_req;
  logic       mem_wr_ack;
  logic [7:0] mem_wr_data;
  alu_ctl_t   alu_ctl;
  logic [7:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       wb_en;
  logic [2:0] wb_sel;
  logic [7:0] wb_data;
  logic       flag_we;
  logic       flag_z;
  logic       flag_n;
  logic       flag_h;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cb_bit_seq dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .illegal(illegal), .busy(busy), .done(done),
    .reg_data(reg_data),
    .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack),
    .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_ack(mem_wr_ack),
    .mem_wr_data(mem_wr_data),
    .alu_ctl(alu_ctl), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .flag_we(flag_we), .flag_z(flag_z),
    .flag_n(flag_n), .flag_h(flag_h)
  );

  // ALU: bit-select and operand registers, mask function
  logic [2:0] a_bs;
  logic [7:0] a_a;
  logic [7:0] a_m;
  logic [7:0] a_f;

  always_ff @(posedge clk) begin
    if (alu_ctl.lb == BUS_LD) a_bs <= alu_ctl.bs;
    if (alu_ctl.la == BUS_LD) a_a  <= alu_op;
  end

  always_comb begin
    a_m = 8'h01 << a_bs;
    if (alu_ctl.r)       a_f = a_a | a_m;
    else if (alu_ctl.ne) a_f = a_a & ~a_m;
    else                 a_f = a_a & a_m;
    alu_result = (alu_ctl.oe == RES_OE) ? a_f : 8'h00;
    alu_zero   = (alu_ctl.oe == RES_OE) && (a_f == 8'h00);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit ctl_idle(input alu_ctl_t c);
    return c.oe == NO_OE && c.la == NO_LD && c.lb == NO_LD &&
      c.bs == 3'd0 && c.sh == NO_SH &&
      {c.r, c.s, c.v, c.ne, c.ci, c.l, c.h} == 7'd0;
  endfunction

  task automatic run_op(input logic [7:0] opc, input logic [7:0] val,
                        input int rl, input int wl);
    logic [2:0] b, r;
    logic [1:0] kind;
    logic [7:0] mask, exp_v, gwd, gwr;
    logic [2:0] gsel;
    logic       gz, gn, gh, exp_z;
    bit         hl, busy_ok;
    int         rc, wc, dcyc, nfw, nwb, nwr, exp_d;
    b     = opc[5:3];
    r     = opc[2:0];
    kind  = opc[7:6];
    hl    = (r == 3'd6);
    mask  = 8'h01 << b;
    exp_v = (kind == 2'b10) ? (val & ~mask) : (val | mask);
    exp_z = ((val & mask) == 8'h00);
    exp_d = (hl ? rl : 0) + ((kind == 2'b01) ? 3 : (hl ? 3 + wl : 4));
    gz = 0; gn = 0; gh = 0; gsel = 0; gwd = 0; gwr = 0;
    rc = 0; wc = 0; dcyc = -1; nfw = 0; nwb = 0; nwr = 0;
    busy_ok = 1;
    reg_data    = val;
    mem_rd_data = val;
    opcode      = opc;
    start       = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 40 && dcyc < 0; c++) begin
      mem_rd_ack = 1'b0;
      mem_wr_ack = 1'b0;
      if (mem_rd_req === 1'b1) begin
        rc++;
        mem_rd_ack = (rc >= rl);
      end
      if (mem_wr_req === 1'b1) begin
        wc++;
        mem_wr_ack = (wc >= wl);
      end
      #1;
      if (busy !== 1'b1) busy_ok = 0;
      if (flag_we === 1'b1) begin
        nfw++; gz = flag_z; gn = flag_n; gh = flag_h;
      end
      if (wb_en === 1'b1) begin
        nwb++; gsel = wb_sel; gwd = wb_data;
      end
      if (mem_wr_req === 1'b1 && mem_wr_ack) begin
        nwr++; gwr = mem_wr_data;
      end
      if (done === 1'b1) dcyc = c;
      tick;
    end
    mem_rd_ack = 1'b0;
    mem_wr_ack = 1'b0;
    #1;
    checks++;
    if (dcyc != exp_d) begin
      errors++;
      $display("FAIL done_cycle op=%h got %0d expected %0d", opc, dcyc, exp_d);
    end
    checks++;
    if (!busy_ok || busy !== 1'b0 || !ctl_idle(alu_ctl)) begin
      errors++;
      $display("FAIL busy_span op=%h busy_ok=%0d busy_after=%b idle=%0d expected 1/0/1",
               opc, busy_ok, busy, ctl_idle(alu_ctl));
    end
    checks++;
    if (nfw != ((kind == 2'b01) ? 1 : 0) ||
        nwb != ((kind != 2'b01 && !hl) ? 1 : 0) ||
        nwr != ((kind != 2'b01 && hl) ? 1 : 0)) begin
      errors++;
      $display("FAIL writes op=%h got fw=%0d wb=%0d wr=%0d", opc, nfw, nwb, nwr);
    end
    if (kind == 2'b01 && nfw == 1) begin
      checks++;
      if (gz !== exp_z || gn !== 1'b0 || gh !== 1'b1) begin
        errors++;
        $display("FAIL bit_flags op=%h val=%h got z%b n%b h%b expected z%b n0 h1",
                 opc, val, gz, gn, gh, exp_z);
      end
    end
    if (nwb == 1) begin
      checks++;
      if (gsel !== r || gwd !== exp_v) begin
        errors++;
        $display("FAIL reg_wb op=%h got sel=%0d data=%h expected sel=%0d data=%h",
                 opc, gsel, gwd, r, exp_v);
      end
    end
    if (nwr == 1) begin
      checks++;
      if (gwr !== exp_v) begin
        errors++;
        $display("FAIL mem_wr op=%h got %h expected %h", opc, gwr, exp_v);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    checks++;
    if (busy !== 0 || done !== 0 || illegal !== 0 || wb_en !== 0 ||
        flag_we !== 0 || mem_rd_req !== 0 || mem_wr_req !== 0) begin
      errors++;
      $display("FAIL reset_ctrl got b%b d%b i%b wb%b fw%b rr%b wr%b expected all 0",
               busy, done, illegal, wb_en, flag_we, mem_rd_req, mem_wr_req);
    end
    checks++;
    if (!ctl_idle(alu_ctl) || alu_op !== 0 || wb_data !== 0 ||
        mem_wr_data !== 0 || wb_sel !== 0) begin
      errors++;
      $display("FAIL reset_data got ctl=%h op=%h wbd=%h wrd=%h expected idle/0",
               alu_ctl, alu_op, wb_data, mem_wr_data);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_bit_words;
    reg_data = 8'hFE;
    opcode   = 8'h40;
    start    = 1'b1;
    tick;
    opcode = 8'hC7;
    checks++;
    if (alu_ctl.bs !== 3'd0 || alu_ctl.lb !== BUS_LD ||
        alu_ctl.la !== NO_LD || alu_ctl.oe !== BS_OE || busy !== 1) begin
      errors++;
      $display("FAIL bsel_word got %h busy=%b expected bs0 BS_OE lb", alu_ctl, busy);
    end
    tick;
    checks++;
    if (alu_op !== 8'hFE || alu_ctl.oe !== SH_OE || alu_ctl.la !== BUS_LD ||
        alu_ctl.lb !== NO_LD || alu_ctl.l !== 1 || alu_ctl.h !== 0 ||
        {alu_ctl.r, alu_ctl.s, alu_ctl.v, alu_ctl.ne, alu_ctl.ci} !== 5'b01001) begin
      errors++;
      $display("FAIL opnd_word got ctl=%h op=%h expected AND load of fe", alu_ctl, alu_op);
    end
    start = 1'b0;
    tick;
    checks++;
    if (alu_ctl.oe !== RES_OE || alu_ctl.h !== 1 || alu_ctl.l !== 0 ||
        flag_we !== 1 || flag_z !== 1 || done !== 1 || wb_en !== 0) begin
      errors++;
      $display("FAIL res_word got ctl=%h fw=%b z=%b d=%b wb=%b expected RES_OE fw z d",
               alu_ctl, flag_we, flag_z, done, wb_en);
    end
    tick;
    checks++;
    if (busy !== 0 || done !== 0 || flag_we !== 0) begin
      errors++;
      $display("FAIL bit_end got busy=%b done=%b fw=%b expected 0", busy, done, flag_we);
    end
  endtask

  task automatic test_vectors;
    run_op(8'h7F, 8'h80, 0, 0);
    run_op(8'h40, 8'hFE, 0, 0);
    run_op(8'hD9, 8'h00, 0, 0);
    run_op(8'hBE, 8'hFF, 2, 1);
    run_op(8'h4E, 8'h00, 1, 0);
    run_op(8'hF6, 8'h12, 3, 3);
  endtask

  task automatic test_reset_mid;
    int bad;
    bad      = 0;
    reg_data = 8'h00;
    opcode   = 8'hD9;
    start    = 1'b1;
    tick;
    start = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if (busy !== 0 || !ctl_idle(alu_ctl)) begin
      errors++;
      $display("FAIL reset_mid got busy=%b ctl=%h expected 0/idle", busy, alu_ctl);
    end
    for (int i = 0; i < 6; i++) begin
      if (wb_en !== 0 || flag_we !== 0 || done !== 0 || mem_wr_req !== 0) bad++;
      tick;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet got %0d active cycles expected 0", bad);
    end
  endtask

  task automatic test_illegal;
    opcode = 8'h17;
    start  = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (illegal !== 1 || busy !== 0) begin
      errors++;
      $display("FAIL illegal_pulse got ill=%b busy=%b expected 1/0", illegal, busy);
    end
    tick;
    checks++;
    if (illegal !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL illegal_end got ill=%b busy=%b expected 0/0", illegal, busy);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] o;
      o = {2'($urandom_range(1, 3)), 6'($urandom)};
      run_op(o, 8'($urandom), $urandom_range(1, 3), $urandom_range(1, 3));
    end
  endtask

  initial begin
    start       = 1'b0;
    opcode      = 8'h00;
    reg_data    = 8'h00;
    mem_rd_ack  = 1'b0;
    mem_wr_ack  = 1'b0;
    mem_rd_data = 8'h00;
    reset       = 1'b1;
    test_reset;
    test_bit_words;
    test_vectors;
    test_reset_mid;
    test_illegal;
    test_back_to_back;
    test_vectors;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cb_bit_seq.md
# cb_bit_seq

Micro-sequencer for the CB-prefixed single-bit instructions (BIT/RES/SET b,r and b,(HL)) of the SM83 core. It accepts the decoded second opcode byte and drives the ALU control word cycle by cycle: bit-select load, then operand load, then result output. It then writes back either the flags (BIT) or the modified byte, to the register file or to memory. It sits directly upstream of the ALU and replaces the hand-written microcode lines for these 192 opcodes.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; one clock domain; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- opcode  in  8  CB second byte; [7:6] 01=BIT 10=RES 11=SET, [5:3] bit b, [2:0] operand r (6=(HL))
- illegal  out  1  one-cycle pulse when start is sampled with opcode[7:6]==00
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse in the final cycle
- reg_data  in  8  register-file read of opcode[2:0], valid while busy
- mem_rd_req / mem_rd_ack  out/in  1/1  (HL) read handshake; mem_rd_data in 8
- mem_wr_req / mem_wr_ack  out/in  1/1  (HL) write handshake; mem_wr_data out 8
- alu_ctl  out  alu_ctl_t  ALU control word (bs, oe, la, lb, sh, r, s, v, ne, ci, l, h)
- alu_op  out  8  operand driven onto the ALU bus
- alu_result  in  8; alu_zero  in  1  ALU outputs
- wb_en  out  1; wb_sel  out  3; wb_data  out  8  register write-back
- flag_we  out  1; flag_z, flag_n, flag_h  out  1  Z/N/H update; C is never written

## Operation
- States: IDLE, RD, BSEL, OPND, RES, WB, WR.
- IDLE: start with a legal opcode latches opcode; next state is RD if r==6, else BSEL. start with an illegal opcode pulses illegal and stays in IDLE.
- RD: mem_rd_req held high until mem_rd_ack is sampled high (same-cycle ack counts); mem_rd_data is latched as the operand; next state BSEL.
- BSEL: bs=b, oe=BS_OE, lb=BUS_LD, la=NO_LD.
- OPND: alu_op=operand (reg_data or latched memory byte), sh=NO_SH, oe=SH_OE, la=BUS_LD, lb=NO_LD, function fields from the per-op constant, l=1, h=0.
- RES: la=lb=NO_LD, oe=RES_OE, same function fields, l=0, h=1.
  - BIT: flag_we=1, flag_z=alu_zero, flag_n=0, flag_h=1, done=1; next state IDLE.
  - RES/SET: alu_result is latched; next state WB (register) or WR ((HL)).
- WB: wb_en=1, wb_sel=r, wb_data=latched result, done=1; next state IDLE.
- WR: mem_wr_req high, mem_wr_data=latched result, until mem_wr_ack; done is pulsed in the ack cycle; next state IDLE.
- Function constants: AND for BIT ({r,s,v,ne,ci}=0,1,0,0,1), ANDN for RES (0,1,0,1,1), OR for SET (1,1,0,0,0).
- Idle control word: oe=NO_OE, la=lb=NO_LD, all other fields 0.
- start while busy is ignored.

## Timing
- Reset values: state IDLE; busy, done, illegal, wb_en, flag_we, mem_rd_req, mem_wr_req all 0; alu_ctl = idle word; data outputs 0.
- Reset mid-operation: state returns to IDLE in the next cycle. Pending requests are dropped, no write-back or flag write occurs, and the latched opcode is discarded.
- Register operand, start accepted at cycle 0:
  - BSEL at 1, OPND at 2, RES at 3.
  - BIT: done at 3, latency 3.
  - RES/SET: wb_en and done at 4, latency 4.
- (HL) operand: RD adds N>=1 cycles (cycles up to and including ack). RES/SET add the WR cycles. A back-to-back start is accepted in the cycle after done.
- Outputs are registered from state. alu_zero and alu_result are sampled in RES only.

## Structure
- Package cb_seq_pkg holds:
  - alu_ctl_t and the oe/ld/sh enums, shared with the ALU (BS_OE, SH_OE, RES_OE, NO_OE, BUS_LD, NO_LD, NO_SH);
  - the FN_AND, FN_ANDN and FN_OR constants;
  - the state enum.
- A single module is sufficient; no sub-module is needed.

## Test plan
- BIT 7,A (0x7F), A=0x80 -> cycle 3: flag_we=1, flag_z=0, flag_h=1, flag_n=0; no wb_en.
- BIT 0,B (0x40), B=0xFE -> cycle 3: flag_z=1; cycle 1: alu_ctl.bs=0, lb=BUS_LD.
- SET 3,C (0xD9), C=0x00 -> cycle 4: wb_en=1, wb_sel=1, wb_data=0x08; flag_we never high.
- RES 7,(HL) (0xBE), mem=0xFF, read ack after 2 cycles, write ack after 1 -> mem_wr_data=0x7F, done in the write-ack cycle.
- reset asserted in OPND -> next cycle busy=0, alu_ctl idle; no wb_en or flag_we follows.
- start with 0x17 -> illegal pulse for one cycle, busy stays 0.
